fib_bcd_front: RTL and testbench

Front-end stage of the Fibonacci datapath. It accepts a two-digit BCD index, converts it to binary, validates the range, and computes the Fibonacci number iteratively. It then hands the 13-bit binary result to the downstream binary-to-BCD converter through that converter's start/ready handshake. Out-of-range or malformed input raises an overflow flag instead of producing a result.

---
 rtl/fib_bcd_front_if.sv | 31 +++
 rtl/fib_bcd_front.sv | 131 +++++++++++++
 tb/tb_fib_bcd_front.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fib_bcd_front_if.sv
// fib_bcd_front_if: request/result bus of the Fibonacci front-end plus the
// start/ready handshake towards the downstream binary-to-BCD converter.
//   start, bcd1, bcd0 : request and two-digit BCD index (requester -> front-end)
//   ready, done_tick  : idle indication / completion pulse (front-end -> requester)
//   overflow, f       : registered result (front-end -> requester and converter)
//   conv_start        : one-cycle start pulse to the converter
//   conv_ready        : converter idle, can accept a start
// The slave modport is the front-end view; master is the surrounding system.
interface fib_bcd_front_if #(
  parameter int W = 13
);
  logic         start;
  logic [3:0]   bcd1;
  logic [3:0]   bcd0;
  logic         ready;
  logic         done_tick;
  logic         overflow;
  logic [W-1:0] f;
  logic         conv_start;
  logic         conv_ready;

  modport slave (
    input  start, bcd1, bcd0, conv_ready,
    output ready, done_tick, overflow, f, conv_start
  );

  modport master (
    output start, bcd1, bcd0, conv_ready,
    input  ready, done_tick, overflow, f, conv_start
  );
endinterface

// File: rtl/fib_bcd_front.sv
// fib_bcd_front: converts a latched two-digit BCD index to binary, range
// checks it, iterates fib(i) one step per cycle and hands the W-bit result
// to the downstream converter through its start/ready handshake.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fib_bcd_front_if.slave (request, result, converter handshake)
module fib_bcd_front #(
  parameter int W     = 13,
  parameter int I_MAX = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  fib_bcd_front_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CONV = 3'd1,
    OP   = 3'd2,
    HAND = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   bcd1_q, bcd1_d;
  logic [3:0]   bcd0_q, bcd0_d;
  logic [W-1:0] t0_q, t0_d;
  logic [W-1:0] t1_q, t1_d;
  logic [4:0]   n_q, n_d;
  logic [W-1:0] f_q, f_d;
  logic         overflow_q, overflow_d;
  logic [6:0]   idx;
  logic         conv_start;
  logic         done_tick;

  // bcd1*10 as bcd1*8 + bcd1*2; 7 bits covers the legal maximum of 99.
  // Malformed digits can wrap here, but they are rejected before idx is used.
  assign idx = {bcd1_q, 3'b000} + {2'b00, bcd1_q, 1'b0} + {3'b000, bcd0_q};

  always_comb begin
    state_d    = state_q;
    bcd1_d     = bcd1_q;
    bcd0_d     = bcd0_q;
    t0_d       = t0_q;
    t1_d       = t1_q;
    n_d        = n_q;
    f_d        = f_q;
    overflow_d = overflow_q;
    conv_start = 1'b0;
    done_tick  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bcd1_d  = bus.bcd1;
          bcd0_d  = bus.bcd0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (bcd1_q > 4'd9 || bcd0_q > 4'd9 || idx > 7'(I_MAX)) begin
          overflow_d = 1'b1;
          f_d        = '0;
          state_d    = HAND;
        end else begin
          overflow_d = 1'b0;
          t0_d       = '0;
          t1_d       = W'(1);
          n_d        = idx[4:0];
          state_d    = OP;
        end
      end
      OP: begin
        // Invariant: t1 = fib(i-n+1), t0 = fib(i-n); stop when n reaches 1.
        if (n_q == 5'd0) begin
          f_d     = '0;
          state_d = HAND;
        end else if (n_q == 5'd1) begin
          f_d     = t1_q;
          state_d = HAND;
        end else begin
          t1_d = t1_q + t0_q;
          t0_d = t1_q;
          n_d  = n_q - 5'd1;
        end
      end
      HAND: begin
        // Combinational so the pulse lands in the very cycle the converter is ready.
        if (bus.conv_ready) begin
          conv_start = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        done_tick = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bcd1_q     <= '0;
      bcd0_q     <= '0;
      t0_q       <= '0;
      t1_q       <= '0;
      n_q        <= '0;
      f_q        <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd1_q     <= bcd1_d;
      bcd0_q     <= bcd0_d;
      t0_q       <= t0_d;
      t1_q       <= t1_d;
      n_q        <= n_d;
      f_q        <= f_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.ready      = (state_q == IDLE);
  assign bus.done_tick  = done_tick;
  assign bus.conv_start = conv_start;
  assign bus.f          = f_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_fib_bcd_front.sv
module tb_fib_bcd_front;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  fib_bcd_front_if #(.W(13)) bus ();

  fib_bcd_front #(.W(13), .I_MAX(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  b1;
    logic [3:0]  b0;
    logic [12:0] ef;
    logic        eo;
    int          ed;   // cycle of done_tick, counted from the start-sampling edge
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One request. stall = HAND cycles with conv_ready low; repulse = cycle in
  // which start is pulsed again (0 = never).
  task automatic run_req(input logic [3:0] b1, input logic [3:0] b0,
                         input int stall, input int repulse,
                         input logic [12:0] ef, input logic eo, input int ed);
    int cyc, guard, cs_cnt, cs_cyc, dn_cnt, dn_cyc, f_bad, hand_start;
    string tag;
    tag = $sformatf("req %0h/%0h", b1, b0);
    hand_start = ed - 1 - stall;
    guard = 0;
    while (!bus.ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready_before_start"}, int'(bus.ready), 1);
    bus.bcd1 = b1;
    bus.bcd0 = b0;
    bus.start = 1'b1;
    bus.conv_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.bcd1 = 4'hF;   // later digit changes must not matter
    bus.bcd0 = 4'hF;
    cyc = 1;
    cs_cnt = 0; cs_cyc = -1; dn_cnt = 0; dn_cyc = -1; f_bad = 0;
    bus.conv_ready = !(stall > 0 && cyc >= hand_start && cyc < hand_start + stall);
    bus.start = (cyc == repulse);
    #1;
    check({tag, " ready_drop"}, int'(bus.ready), 0);
    while (dn_cnt == 0 && cyc < 80) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.conv_ready = !(stall > 0 && cyc >= hand_start && cyc < hand_start + stall);
      bus.start = (cyc == repulse);
      #1;
      if (cyc >= hand_start && bus.f !== ef) f_bad++;
      if (bus.conv_start) begin cs_cnt++; cs_cyc = cyc; end
      if (bus.done_tick) begin dn_cnt++; dn_cyc = cyc; end
    end
    bus.start = 1'b0;
    bus.conv_ready = 1'b1;
    check({tag, " no_timeout"}, int'(dn_cnt > 0), 1);
    check({tag, " f"}, int'(bus.f), int'(ef));
    check({tag, " overflow"}, int'(bus.overflow), int'(eo));
    check({tag, " done_cycle"}, dn_cyc, ed);
    check({tag, " conv_start_cycle"}, cs_cyc, ed - 1);
    check({tag, " conv_start_count"}, cs_cnt, 1);
    check({tag, " f_stable_in_hand"}, f_bad, 0);
    @(posedge clk);
    #2;
    check({tag, " ready_return"}, int'(bus.ready), 1);
    check({tag, " done_single"}, int'(bus.done_tick), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    // Valid index i: CONV in cycle 1, OP max(i,1) cycles, HAND, then DONE
    // in cycle max(i,1)+3. Invalid: CONV, HAND, DONE in cycle 3.
    vecs[0]  = '{4'h0, 4'h0, 13'd0,    1'b0, 4};
    vecs[1]  = '{4'h0, 4'h1, 13'd1,    1'b0, 4};
    vecs[2]  = '{4'h1, 4'h0, 13'd55,   1'b0, 13};
    vecs[3]  = '{4'h2, 4'h0, 13'd6765, 1'b0, 23};
    vecs[4]  = '{4'h2, 4'h1, 13'd0,    1'b1, 3};
    vecs[5]  = '{4'h0, 4'hA, 13'd0,    1'b1, 3};
    vecs[6]  = '{4'h9, 4'h9, 13'd0,    1'b1, 3};
    vecs[7]  = '{4'hA, 4'h0, 13'd0,    1'b1, 3};
    vecs[8]  = '{4'h0, 4'h2, 13'd1,    1'b0, 5};
    vecs[9]  = '{4'h1, 4'h9, 13'd4181, 1'b0, 22};
    vecs[10] = '{4'h1, 4'h5, 13'd610,  1'b0, 18};

    bus.start = 1'b0;
    bus.bcd1 = 4'h0;
    bus.bcd0 = 4'h0;
    bus.conv_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", int'(bus.ready), 1);
    check("reset f", int'(bus.f), 0);
    check("reset overflow", int'(bus.overflow), 0);
    check("reset conv_start", int'(bus.conv_start), 0);
    check("reset done_tick", int'(bus.done_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 11; k++)
      run_req(vecs[k].b1, vecs[k].b0, 0, 0, vecs[k].ef, vecs[k].eo, vecs[k].ed);

    // Converter stall of 5 cycles plus a start pulse during OP that must be ignored.
    run_req(4'h0, 4'h5, 5, 4, 13'd5, 1'b0, 13);
    repeat (2) @(posedge clk);
    #1;
    check("stall idle_after", int'(bus.ready), 1);
    check("stall f_hold", int'(bus.f), 5);

    // Reset in the middle of an index-20 computation.
    @(negedge clk);
    bus.bcd1 = 4'h2;
    bus.bcd0 = 4'h0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset busy", int'(bus.ready), 0);
    rst_n = 1'b0;
    #1;
    check("midreset ready", int'(bus.ready), 1);
    check("midreset f", int'(bus.f), 0);
    check("midreset overflow", int'(bus.overflow), 0);
    check("midreset conv_start", int'(bus.conv_start), 0);
    check("midreset done_tick", int'(bus.done_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_req(4'h0, 4'h7, 0, 0, 13'd13, 1'b0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
